// File: rtl/lc3_writeback.sv
// rtl/lc3_writeback.sv - LC-3 writeback stage: result FIFO, regfile write strobe, NZP and pending-write vector
module lc3_writeback #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_dr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_wen,
  input  logic             in_setcc,
  input  logic             hold,
  output logic             rf_we,
  output logic [2:0]       rf_dr,
  output logic [WIDTH-1:0] rf_data,
  output logic [2:0]       nzp,
  output logic [7:0]       pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]       drMem    [DEPTH];
  logic [WIDTH-1:0] dataMem  [DEPTH];
  logic             wenMem   [DEPTH];
  logic             setccMem [DEPTH];

  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] count;
  logic [PW-1:0] idx;
  logic          full;
  logic          doPush;
  logic          doPop;
  logic [WIDTH-1:0] headData;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full && !rst;
  assign doPush   = in_valid && in_ready;
  assign doPop    = (count != '0) && !hold;
  assign headData = dataMem[headPtr];

  // Storage carries no reset: entries beyond count are never observed.
  always_ff @(posedge clk) begin
    if (doPush) begin
      drMem[tailPtr]    <= in_dr;
      dataMem[tailPtr]  <= in_data;
      wenMem[tailPtr]   <= in_wen;
      setccMem[tailPtr] <= in_setcc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      rf_we   <= 1'b0;
      rf_dr   <= 3'd0;
      rf_data <= '0;
      nzp     <= 3'b010;
    end else begin
      if (doPush) tailPtr <= tailPtr + PW'(1);
      if (doPop) begin
        headPtr <= headPtr + PW'(1);
        rf_we   <= wenMem[headPtr];
        rf_dr   <= drMem[headPtr];
        rf_data <= headData;
        if (setccMem[headPtr]) begin
          if (headData[WIDTH-1])    nzp <= 3'b100;
          else if (headData == '0)  nzp <= 3'b010;
          else                      nzp <= 3'b001;
        end
      end else begin
        rf_we <= 1'b0;
      end
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // A register stays pending until the cycle after its regfile write edge.
  always_comb begin
    pending = 8'd0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PW'(i);
      if ((CW'(i) < count) && wenMem[idx]) pending[drMem[idx]] = 1'b1;
    end
    if (rf_we) pending[rf_dr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(doPush && full));
      assert (!(doPop && (count == '0)));
    end
  end

endmodule

// File: tb/tb_lc3_writeback.sv
// tb/tb_lc3_writeback.sv - bench for lc3_writeback: directed cases then random traffic against a queue model
module tb_lc3_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_dr;
  logic [15:0] in_data;
  logic        in_wen;
  logic        in_setcc;
  logic        hold;
  logic        rf_we;
  logic [2:0]  rf_dr;
  logic [15:0] rf_data;
  logic [2:0]  nzp;
  logic [7:0]  pending;

  always #5 clk = ~clk;

  lc3_writeback #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dr(in_dr), .in_data(in_data), .in_wen(in_wen), .in_setcc(in_setcc),
    .hold(hold), .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data),
    .nzp(nzp), .pending(pending)
  );

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
    logic        wen;
    logic        setcc;
  } ent_t;

  ent_t        q[$];
  logic        mWe;
  logic [2:0]  mDr;
  logic [15:0] mData;
  logic [2:0]  mNzp;
  int          nChecks = 0;
  int          nErr = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] signOf(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [7:0] expPending();
    logic [7:0] p = 8'd0;
    foreach (q[i]) if (q[i].wen) p[q[i].dr] = 1'b1;
    if (mWe) p[mDr] = 1'b1;
    return p;
  endfunction

  // One clock: check current outputs, apply inputs, check in_ready, advance the model.
  task automatic step(input logic r, input logic v, input logic [2:0] d, input logic [15:0] dat,
                      input logic w, input logic s, input logic h);
    ent_t e;
    bit acc;
    bit pop;
    @(negedge clk);
    chk("rf_we",   16'(rf_we),   16'(mWe));
    chk("rf_dr",   16'(rf_dr),   16'(mDr));
    chk("rf_data", rf_data,      mData);
    chk("nzp",     16'(nzp),     16'(mNzp));
    chk("pending", 16'(pending), 16'(expPending()));
    rst = r; in_valid = v; in_dr = d; in_data = dat; in_wen = w; in_setcc = s; hold = h;
    #1;
    chk("in_ready", 16'(in_ready), 16'(!r && (q.size() < DEPTH)));
    @(posedge clk);
    if (r) begin
      q.delete();
      mWe = 1'b0; mDr = 3'd0; mData = 16'd0; mNzp = 3'b010;
    end else begin
      acc = v && (q.size() < DEPTH);
      pop = (q.size() > 0) && !h;
      if (pop) begin
        e = q.pop_front();
        mWe = e.wen; mDr = e.dr; mData = e.data;
        if (e.setcc) mNzp = signOf(e.data);
      end else begin
        mWe = 1'b0;
      end
      if (acc) begin
        e.dr = d; e.data = dat; e.wen = w; e.setcc = s;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_dr = 3'd5; in_data = 16'h1234;
    in_wen = 1'b1; in_setcc = 1'b1; hold = 1'b0;
    mWe = 1'b0; mDr = 3'd0; mData = 16'd0; mNzp = 3'b010;
    @(posedge clk);

    // reset held with valid high: nothing accepted
    step(1, 1, 3'd5, 16'h1234, 1, 1, 0);
    step(1, 1, 3'd6, 16'h4321, 1, 1, 0);

    // single write
    step(0, 1, 3'd3, 16'h8001, 1, 1, 0);
    repeat (4) step(0, 0, 3'd0, 16'h0000, 0, 0, 0);

    // back-to-back
    step(0, 1, 3'd1, 16'h0000, 1, 1, 0);
    step(0, 1, 3'd2, 16'h0005, 1, 1, 0);
    step(0, 1, 3'd7, 16'hFFFF, 1, 1, 0);
    repeat (4) step(0, 0, 3'd0, 16'h0000, 0, 0, 0);

    // full under hold, refused third push, then drain
    step(0, 1, 3'd4, 16'h0010, 1, 1, 1);
    step(0, 1, 3'd5, 16'h8000, 1, 1, 1);
    step(0, 1, 3'd6, 16'h0001, 1, 1, 1);
    step(0, 1, 3'd6, 16'h0001, 1, 1, 0);
    repeat (4) step(0, 0, 3'd0, 16'h0000, 0, 0, 0);

    // flags-only entry
    step(0, 1, 3'd2, 16'h8000, 1, 1, 0);
    step(0, 1, 3'd3, 16'h0000, 0, 1, 0);
    repeat (3) step(0, 0, 3'd0, 16'h0000, 0, 0, 0);

    // reset mid-drain
    step(0, 1, 3'd1, 16'h7000, 1, 1, 1);
    step(0, 1, 3'd2, 16'h9000, 1, 1, 1);
    step(0, 0, 3'd0, 16'h0000, 0, 0, 0);
    step(1, 0, 3'd0, 16'h0000, 0, 0, 0);
    step(0, 1, 3'd6, 16'h0042, 1, 1, 0);
    repeat (3) step(0, 0, 3'd0, 16'h0000, 0, 0, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0));
    end
    repeat (4) step(0, 0, 3'd0, 16'h0000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
    $finish;
  end

endmodule
